sdram_master_arbiter: RTL and testbench

SDRAM_MASTER_ARBITER -- requirements
Module: sdram_master_arbiter

---
 rtl/sdram_master_arbiter.sv | 234 +++++++++++++++++++++++
 tb/tb_sdram_master_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sdram_master_arbiter.sv
// sdram_master_arbiter: three-requester arbiter in front of a single SDRAM
// controller port. Grants one requester at a time for up to MAX_BURST
// accepted transfers, and routes returning read data back to the issuer
// through an in-order tag FIFO.
// Optional build macro: SDRAM_ARB_ROUND_ROBIN_EN selects round-robin
// arbitration; when undefined, fixed priority (0 > 1 > 2) is used.
module sdram_master_arbiter #(
  parameter int unsigned MAX_BURST = 8,
  parameter int unsigned TAG_DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [25:0] s0_address,
  input  logic        s0_read,
  input  logic        s0_write,
  input  logic [3:0]  s0_byteenable,
  input  logic [31:0] s0_writedata,
  output logic [31:0] s0_readdata,
  output logic        s0_readdatavalid,
  output logic        s0_waitrequest,
  input  logic [25:0] s1_address,
  input  logic        s1_read,
  input  logic        s1_write,
  input  logic [3:0]  s1_byteenable,
  input  logic [31:0] s1_writedata,
  output logic [31:0] s1_readdata,
  output logic        s1_readdatavalid,
  output logic        s1_waitrequest,
  input  logic [25:0] s2_address,
  input  logic        s2_read,
  input  logic        s2_write,
  input  logic [3:0]  s2_byteenable,
  input  logic [31:0] s2_writedata,
  output logic [31:0] s2_readdata,
  output logic        s2_readdatavalid,
  output logic        s2_waitrequest,
  output logic [25:0] m_address,
  output logic [3:0]  m_byteenable,
  output logic [31:0] m_writedata,
  output logic        m_read,
  output logic        m_write,
  input  logic [31:0] m_readdata,
  input  logic        m_readdatavalid,
  input  logic        m_waitrequest
);

  localparam int unsigned PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam int unsigned CNT_W = 8;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state, state_nxt;
  logic [1:0]       gnt, gnt_nxt;
  logic [CNT_W-1:0] burst_cnt, burst_cnt_nxt;

  logic [2:0]       req, wr_req, rd_req;
  logic [2:0]       gnt_oh, wait_vec, rdv_vec;
  logic [25:0]      sel_addr;
  logic [3:0]       sel_be;
  logic [31:0]      sel_wd;
  logic             sel_req, sel_wr, sel_rd;
  logic             accept, push, pop, rd_blocked;

  logic [1:0]       tag_mem [TAG_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [OCC_W-1:0] occ;
  logic             full, empty;
  logic [1:0]       head;

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
  logic [1:0]       last_gnt;

  // First requesting index after 'last' in cyclic order 0,1,2.
  function automatic logic [1:0] pick_rr(input logic [2:0] r, input logic [1:0] last);
    int idx;
    pick_rr = 2'd0;
    for (int k = 3; k >= 1; k--) begin
      idx = (int'(last) + k) % 3;
      if (r[idx]) pick_rr = 2'(idx);
    end
  endfunction
`else
  // Lowest requesting index wins.
  function automatic logic [1:0] pick_fixed(input logic [2:0] r);
    if (r[0])      pick_fixed = 2'd0;
    else if (r[1]) pick_fixed = 2'd1;
    else           pick_fixed = 2'd2;
  endfunction
`endif

  // A simultaneous read and write is treated as a write.
  assign wr_req = {s2_write, s1_write, s0_write};
  assign req    = {s2_read | s2_write, s1_read | s1_write, s0_read | s0_write};
  assign rd_req = {s2_read & ~s2_write, s1_read & ~s1_write, s0_read & ~s0_write};

  assign full   = (occ == OCC_W'(TAG_DEPTH));
  assign empty  = (occ == '0);
  assign head   = tag_mem[rd_ptr];
  assign pop    = reset && m_readdatavalid && !empty;
  assign gnt_oh = 3'(1) << gnt;

  // Select the granted requester's command fields.
  always_comb begin : sel_mux
    sel_addr = '0;
    sel_be   = '0;
    sel_wd   = '0;
    sel_req  = 1'b0;
    sel_wr   = 1'b0;
    sel_rd   = 1'b0;
    case (gnt)
      2'd0: begin
        sel_addr = s0_address; sel_be = s0_byteenable; sel_wd = s0_writedata;
        sel_req = req[0]; sel_wr = wr_req[0]; sel_rd = rd_req[0];
      end
      2'd1: begin
        sel_addr = s1_address; sel_be = s1_byteenable; sel_wd = s1_writedata;
        sel_req = req[1]; sel_wr = wr_req[1]; sel_rd = rd_req[1];
      end
      2'd2: begin
        sel_addr = s2_address; sel_be = s2_byteenable; sel_wd = s2_writedata;
        sel_req = req[2]; sel_wr = wr_req[2]; sel_rd = rd_req[2];
      end
      default: ;
    endcase
  end

  // Next-state, burst accounting and master/stall outputs.
  always_comb begin : fsm_comb
    state_nxt     = state;
    gnt_nxt       = gnt;
    burst_cnt_nxt = burst_cnt;
    m_address     = '0;
    m_byteenable  = '0;
    m_writedata   = '0;
    m_read        = 1'b0;
    m_write       = 1'b0;
    wait_vec      = 3'b111;
    accept        = 1'b0;
    push          = 1'b0;
    // A full tag FIFO blocks reads unless a pop frees a slot this cycle.
    rd_blocked    = sel_rd && full && !pop;
    case (state)
      IDLE: begin
        if (|req) begin
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
          gnt_nxt = pick_rr(req, last_gnt);
`else
          gnt_nxt = pick_fixed(req);
`endif
          burst_cnt_nxt = '0;
          state_nxt     = GRANT;
        end
      end
      GRANT: begin
        m_address    = sel_addr;
        m_byteenable = sel_be;
        m_writedata  = sel_wd;
        m_write      = sel_wr;
        m_read       = sel_rd && !rd_blocked;
        wait_vec     = ~gnt_oh | (gnt_oh & {3{m_waitrequest | rd_blocked}});
        accept       = (m_read || m_write) && !m_waitrequest;
        push         = m_read && !m_waitrequest;
        if (accept) burst_cnt_nxt = burst_cnt + CNT_W'(1);
        if (!sel_req || (accept && burst_cnt == CNT_W'(MAX_BURST - 1)))
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Hold everything quiet while reset is asserted.
    if (!reset) begin
      m_read   = 1'b0;
      m_write  = 1'b0;
      wait_vec = 3'b111;
      push     = 1'b0;
    end
  end

  // Read-data routing: the FIFO head names the requester that owns the beat.
  assign rdv_vec          = pop ? (3'(1) << head) : 3'b000;
  assign s0_readdatavalid = rdv_vec[0];
  assign s1_readdatavalid = rdv_vec[1];
  assign s2_readdatavalid = rdv_vec[2];
  assign s0_waitrequest   = wait_vec[0];
  assign s1_waitrequest   = wait_vec[1];
  assign s2_waitrequest   = wait_vec[2];
  assign s0_readdata      = m_readdata;
  assign s1_readdata      = m_readdata;
  assign s2_readdata      = m_readdata;

  // State, grant and burst counter registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      gnt       <= 2'd0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      gnt       <= gnt_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
  // Remember the most recent grant for the round-robin search.
  always_ff @(posedge clock) begin
    if (!reset)                     last_gnt <= 2'd2;
    else if (state == IDLE && |req) last_gnt <= gnt_nxt;
  end
`endif

  // Tag FIFO pointers and occupancy.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: ;
      endcase
    end
  end

  // Tag storage; contents are meaningless while the FIFO is empty.
  always_ff @(posedge clock) begin
    if (push) tag_mem[wr_ptr] <= gnt;
  end

endmodule

// File: tb/tb_sdram_master_arbiter.sv
// Directed bench for sdram_master_arbiter: a per-cycle vector table plus
// hand-written sequences for burst limit, tag-FIFO full and reset cases.
module tb_sdram_master_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  rd = 3'b000, wr = 3'b000;
  logic        mw = 1'b0, mrdv = 1'b0;
  logic [31:0] mrd = 32'h0;

  localparam logic [25:0] A0 = 26'h10, A1 = 26'h100, A2 = 26'h200;
  localparam logic [31:0] D0 = 32'h0A0A0A0A, D1 = 32'hDEADBEEF, D2 = 32'h22222222;

  logic [31:0] rdata0, rdata1, rdata2, m_writedata;
  logic        rdv0, rdv1, rdv2, wt0, wt1, wt2;
  logic [25:0] m_address;
  logic [3:0]  m_byteenable;
  logic        m_read, m_write;
  logic [2:0]  wq, rv;

  assign wq = {wt2, wt1, wt0};
  assign rv = {rdv2, rdv1, rdv0};

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  sdram_master_arbiter #(.MAX_BURST(8), .TAG_DEPTH(8)) dut (
    .clock(clock), .reset(reset),
    .s0_address(A0), .s0_read(rd[0]), .s0_write(wr[0]), .s0_byteenable(4'hF),
    .s0_writedata(D0), .s0_readdata(rdata0), .s0_readdatavalid(rdv0), .s0_waitrequest(wt0),
    .s1_address(A1), .s1_read(rd[1]), .s1_write(wr[1]), .s1_byteenable(4'hF),
    .s1_writedata(D1), .s1_readdata(rdata1), .s1_readdatavalid(rdv1), .s1_waitrequest(wt1),
    .s2_address(A2), .s2_read(rd[2]), .s2_write(wr[2]), .s2_byteenable(4'h3),
    .s2_writedata(D2), .s2_readdata(rdata2), .s2_readdatavalid(rdv2), .s2_waitrequest(wt2),
    .m_address(m_address), .m_byteenable(m_byteenable), .m_writedata(m_writedata),
    .m_read(m_read), .m_write(m_write),
    .m_readdata(mrd), .m_readdatavalid(mrdv), .m_waitrequest(mw)
  );

  typedef struct {
    logic        rst;
    logic [2:0]  rd, wr;
    logic        mw, mrdv;
    logic [31:0] mrd;
    logic        e_rd, e_wr;
    logic [25:0] e_addr;
    logic [31:0] e_wd;
    logic [2:0]  e_wait, e_rdv;
  } vec_t;

  vec_t vt[13];

  function automatic vec_t mk(input logic rst, input logic [2:0] r, w, input logic m_w, m_v,
                              input logic [31:0] m_d, input logic er, ew, input logic [25:0] ea,
                              input logic [31:0] ed, input logic [2:0] ewt, erv);
    vec_t v;
    v.rst = rst; v.rd = r; v.wr = w; v.mw = m_w; v.mrdv = m_v; v.mrd = m_d;
    v.e_rd = er; v.e_wr = ew; v.e_addr = ea; v.e_wd = ed; v.e_wait = ewt; v.e_rdv = erv;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply inputs at the falling edge, let combinational outputs settle.
  task automatic drive(input logic rst, input logic [2:0] r, w, input logic m_w, m_v,
                       input logic [31:0] m_d);
    @(negedge clock);
    reset = rst; rd = r; wr = w; mw = m_w; mrdv = m_v; mrd = m_d;
    #1;
  endtask

  task automatic chk(input string tag, input logic er, ew, input logic [2:0] ewt, erv);
    check({tag, ".m_read"},  32'(m_read),  32'(er));
    check({tag, ".m_write"}, 32'(m_write), 32'(ew));
    check({tag, ".wait"},    32'(wq),      32'(ewt));
    check({tag, ".rdv"},     32'(rv),      32'(erv));
  endtask

  task automatic do_reset();
    drive(1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    int issued[3];
    int rcnt[3];
    int acc, ret, g, cyc;
    logic [2:0] r;

    vt[0]  = mk(0, 3'b000, 3'b000, 0, 0, 32'h0,        0, 0, A0, D0, 3'b111, 3'b000);
    vt[1]  = mk(0, 3'b000, 3'b000, 0, 0, 32'h0,        0, 0, A0, D0, 3'b111, 3'b000);
    vt[2]  = mk(1, 3'b000, 3'b010, 0, 0, 32'h0,        0, 0, A0, D0, 3'b111, 3'b000);
    vt[3]  = mk(1, 3'b000, 3'b010, 0, 0, 32'h0,        0, 1, A1, D1, 3'b101, 3'b000);
    vt[4]  = mk(1, 3'b000, 3'b000, 0, 0, 32'h0,        0, 0, A0, D0, 3'b101, 3'b000);
    vt[5]  = mk(1, 3'b000, 3'b000, 0, 0, 32'h0,        0, 0, A0, D0, 3'b111, 3'b000);
    vt[6]  = mk(1, 3'b001, 3'b000, 0, 0, 32'h0,        0, 0, A0, D0, 3'b111, 3'b000);
    vt[7]  = mk(1, 3'b001, 3'b000, 1, 0, 32'h0,        1, 0, A0, D0, 3'b111, 3'b000);
    vt[8]  = mk(1, 3'b001, 3'b000, 0, 0, 32'h0,        1, 0, A0, D0, 3'b110, 3'b000);
    vt[9]  = mk(1, 3'b001, 3'b001, 0, 0, 32'h0,        0, 1, A0, D0, 3'b110, 3'b000);
    vt[10] = mk(1, 3'b000, 3'b000, 0, 1, 32'h12345678, 0, 0, A0, D0, 3'b110, 3'b001);
    vt[11] = mk(1, 3'b000, 3'b000, 0, 1, 32'h87654321, 0, 0, A0, D0, 3'b111, 3'b000);
    vt[12] = mk(1, 3'b000, 3'b000, 0, 0, 32'h0,        0, 0, A0, D0, 3'b111, 3'b000);

    // Table: reset, single write, stalled/accepted read, write precedence, routing.
    for (int i = 0; i < 13; i++) begin
      drive(vt[i].rst, vt[i].rd, vt[i].wr, vt[i].mw, vt[i].mrdv, vt[i].mrd);
      chk($sformatf("vec%0d", i), vt[i].e_rd, vt[i].e_wr, vt[i].e_wait, vt[i].e_rdv);
      if (vt[i].e_rd || vt[i].e_wr)
        check($sformatf("vec%0d.addr", i), 32'(m_address), 32'(vt[i].e_addr));
      if (vt[i].e_wr)
        check($sformatf("vec%0d.wdata", i), m_writedata, vt[i].e_wd);
      if (vt[i].e_rdv != 3'b000)
        check($sformatf("vec%0d.rdata", i), rdata0, vt[i].mrd);
    end

    // Three requesters, three reads each, data returned on alternate cycles.
    do_reset();
    issued = '{0, 0, 0};
    rcnt   = '{0, 0, 0};
    acc = 0; ret = 0; cyc = 0;
    while (ret < 9 && cyc < 80) begin
      r = {issued[2] < 3, issued[1] < 3, issued[0] < 3};
      drive(1'b1, r, 3'b000, 1'b0, (ret < acc) && (cyc % 2 == 1), 32'hA0000000 + 32'(ret));
      for (int k = 0; k < 3; k++) rcnt[k] += int'(rv[k]);
      if (mrdv) begin
        check($sformatf("rr.rdv%0d", ret), 32'(rv), 32'(3'(1) << (ret / 3)));
        check($sformatf("rr.rdata%0d", ret), rdata0 ^ rdata1 ^ rdata2, mrd);
        ret++;
      end
      if (m_read) begin
        g = (wq == 3'b110) ? 0 : (wq == 3'b101) ? 1 : (wq == 3'b011) ? 2 : 3;
        check($sformatf("rr.grant%0d", acc), 32'(g), 32'(acc / 3));
        if (g < 3) begin
          check($sformatf("rr.addr%0d", acc), 32'(m_address),
                32'((g == 0) ? A0 : (g == 1) ? A1 : A2));
          issued[g]++;
        end
        acc++;
      end
      cyc++;
    end
    check("rr.returns", 32'(ret), 32'd9);
    for (int k = 0; k < 3; k++) check($sformatf("rr.count%0d", k), 32'(rcnt[k]), 32'd3);

    // Burst limit: s0 reads continuously, s2 waits with a write.
    do_reset();
    for (int c = 0; c <= 10; c++) begin
      drive(1'b1, 3'b001, 3'b100, 1'b0, 1'b0, 32'h0);
      if (c == 0 || c == 9) chk($sformatf("burst.c%0d", c), 0, 0, 3'b111, 3'b000);
      else if (c <= 8)      chk($sformatf("burst.c%0d", c), 1, 0, 3'b110, 3'b000);
      else begin
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
        chk("burst.c10", 0, 1, 3'b011, 3'b000);
        check("burst.c10.addr", 32'(m_address), 32'(A2));
`else
        chk("burst.c10", 0, 0, 3'b111, 3'b000);
`endif
      end
    end

    // Tag FIFO full: 8 reads accepted, then blocked until a read beat pops a tag.
    do_reset();
    for (int c = 0; c <= 16; c++) begin
      logic v;
      v = (c == 13 || c == 15);
      drive(1'b1, (c == 16) ? 3'b000 : 3'b001, 3'b000, 1'b0, v, 32'h50 + 32'(c));
      if (c == 0 || c == 9)     chk($sformatf("full.c%0d", c), 0, 0, 3'b111, 3'b000);
      else if (c <= 8)          chk($sformatf("full.c%0d", c), 1, 0, 3'b110, 3'b000);
      else if (c <= 12 || c == 14) chk($sformatf("full.c%0d", c), 0, 0, 3'b111, 3'b000);
      else if (v) begin
        chk($sformatf("full.c%0d", c), 1, 0, 3'b110, 3'b001);
        check($sformatf("full.c%0d.rdata", c), rdata0, 32'h50 + 32'(c));
      end else                  chk("full.c16", 0, 0, 3'b110, 3'b000);
    end

    // Reset with three reads outstanding: late data dropped, stalls held.
    do_reset();
    drive(1'b1, 3'b001, 3'b000, 1'b0, 1'b0, 32'h0);
    chk("rst.idle", 0, 0, 3'b111, 3'b000);
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 3'b001, 3'b000, 1'b0, 1'b0, 32'h0);
      chk($sformatf("rst.rd%0d", c), 1, 0, 3'b110, 3'b000);
    end
    drive(1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 32'h0);
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, 3'b001, 3'b000, 1'b0, 1'b1, 32'hBAD0 + 32'(c));
      chk($sformatf("rst.in%0d", c), 0, 0, 3'b111, 3'b000);
    end
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 3'b000, 3'b000, 1'b0, 1'b1, 32'hBAD8 + 32'(c));
      chk($sformatf("rst.late%0d", c), 0, 0, 3'b111, 3'b000);
    end
    drive(1'b1, 3'b100, 3'b000, 1'b0, 1'b0, 32'h0);
    chk("rst.req", 0, 0, 3'b111, 3'b000);
    drive(1'b1, 3'b100, 3'b000, 1'b0, 1'b0, 32'h0);
    chk("rst.grant", 1, 0, 3'b011, 3'b000);
    check("rst.grant.addr", 32'(m_address), 32'(A2));
    drive(1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
